// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder: computes a_in + b_in + cin one bit per clock, LSB first,
// using a single full adder. A three-state FSM (IDLE, SHIFT, DONE) sequences
// the operation. A start is accepted in IDLE or DONE, so back-to-back adds
// are possible without an idle cycle in between.
//
// Parameters
//   WIDTH    operand/result width in bits (legal 2..32, default 8)
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request a new addition (accepted in IDLE or DONE only)
//   a_in     operand A, captured on the accepting edge
//   b_in     operand B, captured on the accepting edge
//   cin      carry-in, captured on the accepting edge
//   busy     high while result bits are being computed (state SHIFT)
//   done     one-cycle pulse when the result first becomes valid (state DONE)
//   sum_out  result, held from done until the next accepted start
//   cout     carry-out, held over the same window as sum_out
//   ovf      signed overflow (only with SERIAL_ADDER_OVF_EN defined)
//
// Configuration
//   SERIAL_ADDER_OVF_EN  when defined, adds the ovf output and its logic.
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt;
  logic             busy_reg;
  logic             done_reg;

`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_reg;
`endif

  // The single full adder, always looking at the current LSBs and carry.
  logic fa_sum;
  logic fa_carry;

  assign fa_sum   = a_reg[0] ^ b_reg[0] ^ carry_reg;
  assign fa_carry = (a_reg[0] & b_reg[0]) | (carry_reg & (a_reg[0] ^ b_reg[0]));

  // A start is only honoured outside SHIFT; requests during SHIFT are dropped.
  logic accept;
  assign accept = start && (state != SHIFT);

  // Sequencer and datapath. busy/done are registered alongside the state so
  // they always equal (state == SHIFT) and (state == DONE) respectively.
  // carry_reg doubles as cout: after the last step it holds the final carry
  // and is untouched until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        SHIFT: begin
          sum_reg   <= {fa_sum, sum_reg[WIDTH-1:1]};
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          carry_reg <= fa_carry;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state    <= DONE;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_reg here is the carry into the MSB position.
            ovf_reg  <= carry_reg ^ fa_carry;
`endif
          end
        end
        default: begin
          if (accept) begin
            a_reg     <= a_in;
            b_reg     <= b_in;
            carry_reg <= cin;
            cnt       <= '0;
            state     <= SHIFT;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
          end else begin
            state     <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign sum_out = sum_reg;
  assign cout    = carry_reg;

`ifdef SERIAL_ADDER_OVF_EN
  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder (WIDTH = 8). Each accepted start
// pushes the expected result onto a scoreboard queue; a monitor pops and
// compares on every done pulse. Also checks reset values, busy length,
// done pulse width, ignored starts during SHIFT, mid-operation reset and
// back-to-back operation. Define SERIAL_ADDER_OVF_EN to also check ovf.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } expect_t;

  expect_t scoreboard[$];
  int      vectorCount = 0;
  int      missCount   = 0;
  int      doneCount   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: plain integer addition, signed overflow from sign bits.
  function automatic expect_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic c);
    expect_t     e;
    logic [WIDTH:0] full;
    full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    expect_t e;
    if (rst_n && done) begin
      doneCount++;
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = scoreboard.pop_front();
        checkOutput("sum_out", 64'(sum_out), 64'(e.sum));
        checkOutput("cout", 64'(cout), 64'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("ovf", 64'(ovf), 64'(e.ovf));
`endif
      end
    end
  end

  task automatic scrambleInputs();
    a_in = WIDTH'($urandom);
    b_in = WIDTH'($urandom);
    cin  = 1'($urandom);
  endtask

  // One complete addition: pulse start, scramble operands afterwards,
  // measure busy length and verify done is a single-cycle pulse.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic c);
    int busyLen;
    bit seen;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    scoreboard.push_back(model(a, b, c));
    busyLen = 0;
    seen    = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      scrambleInputs();
      if (done) seen = 1'b1;
      else if (busy) busyLen++;
    end
    checkOutput("busy_len", 64'(busyLen), 64'd8);
    checkOutput("done_seen", 64'(seen), 64'd1);
    @(negedge clk);
    checkOutput("done_width", 64'(done), 64'd0);
  endtask

  initial begin
    int      busyLen;
    int      doneBefore;
    bit      seen;
    longint  t1;
    longint  t2;

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
    t1    = 0;
    t2    = 0;

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_sum", 64'(sum_out), 64'd0);
    checkOutput("rst_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
`endif

    // Release reset just before a negedge so the first start is taken on
    // the very first rising edge with rst_n high.
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(8'h00, 8'h00, 1'b0);

    // Directed corner cases.
    applyStimulus(8'hFF, 8'h01, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    applyStimulus(8'h7F, 8'h01, 1'b0);
    applyStimulus(8'h80, 8'h80, 1'b0);
    applyStimulus(8'hA5, 8'h5A, 1'b1);

    // Random operations.
    for (int i = 0; i < 6; i++)
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom));

    // A start pulse during SHIFT must be ignored entirely.
    doneBefore = doneCount;
    @(negedge clk);
    a_in  = 8'h12;
    b_in  = 8'h34;
    cin   = 1'b0;
    start = 1'b1;
    scoreboard.push_back(model(8'h12, 8'h34, 1'b0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a_in  = 8'hFF;
    b_in  = 8'hFF;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("ignored_start_dones", 64'(doneCount - doneBefore), 64'd1);
    checkOutput("ignored_start_sum", 64'(sum_out), 64'h46);

    // Reset on the 4th busy cycle aborts the operation.
    doneBefore = doneCount;
    @(negedge clk);
    a_in  = 8'h07;
    b_in  = 8'h01;
    cin   = 1'b1;
    start = 1'b1;
    busyLen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busyLen++;
    end
    checkOutput("pre_abort_busy", 64'(busyLen), 64'd4);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_sum", 64'(sum_out), 64'd0);
    checkOutput("abort_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checkOutput("abort_no_done", 64'(doneCount - doneBefore), 64'd0);
    applyStimulus(8'h3C, 8'h0F, 1'b0);

    // Back-to-back: start held high through DONE.
    @(negedge clk);
    a_in  = 8'h3C;
    b_in  = 8'hA5;
    cin   = 1'b0;
    start = 1'b1;
    scoreboard.push_back(model(8'h3C, 8'hA5, 1'b0));
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        t1   = $time;
        a_in = 8'h81;
        b_in = 8'h7F;
        cin  = 1'b1;
        scoreboard.push_back(model(8'h81, 8'h7F, 1'b1));
      end
    end
    checkOutput("b2b_first_done", 64'(seen), 64'd1);
    @(negedge clk);
    checkOutput("b2b_no_idle", 64'(busy), 64'd1);
    start = 1'b0;
    scrambleInputs();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        t2   = $time;
      end
    end
    checkOutput("b2b_second_done", 64'(seen), 64'd1);
    checkOutput("b2b_gap_cycles", 64'((t2 - t1) / 10), 64'd9);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(scoreboard.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 The module SHALL have exactly one clock and one reset. The reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin an addition; sampled on rising clk.
REQ-006 a_in  input  WIDTH  operand A, captured when start is accepted.
REQ-007 b_in  input  WIDTH  operand B, captured when start is accepted.
REQ-008 cin  input  1  carry-in, captured when start is accepted.
REQ-009 busy  output  1  high while bits are being computed.
REQ-010 done  output  1  one-cycle pulse; high when the result is first valid.
REQ-011 sum_out  output  WIDTH  result sum; valid from done until the next accepted start.
REQ-012 cout  output  1  result carry-out; valid over the same window as sum_out.

Function
REQ-013 The module SHALL compute a_in + b_in + cin bit-serially, LSB first.
REQ-014 Each step SHALL use one combinational full adder on a_reg[0], b_reg[0] and carry_reg.
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 start SHALL be accepted only in the IDLE or DONE state.
REQ-017 On acceptance, the module SHALL:
  - load a_reg and b_reg from a_in and b_in;
  - set carry_reg to cin;
  - clear the bit counter;
  - enter SHIFT.
REQ-018 In each SHIFT cycle, the module SHALL:
  - shift the full-adder sum bit into the MSB of sum_reg (shift right);
  - shift a_reg and b_reg right by one;
  - update carry_reg with the full-adder carry;
  - increment the counter.
REQ-019 After exactly WIDTH SHIFT cycles, the FSM SHALL enter DONE.
REQ-020 Leaving DONE:
  - with no start, the FSM SHALL go to IDLE after one cycle;
  - with start, it SHALL go directly to SHIFT.
REQ-021 Timing: if start is accepted at edge k, busy SHALL be high for the cycles after edges k..k+WIDTH-1 (WIDTH cycles). done SHALL be high for exactly the one cycle after edge k+WIDTH.
REQ-022 busy SHALL equal (state == SHIFT).
REQ-023 done SHALL equal (state == DONE).
REQ-024 sum_out and cout SHALL hold their values from entry to DONE until the next accepted start. They are undefined while busy.
REQ-025 start asserted during SHIFT SHALL be ignored. Captured operands SHALL NOT change, and no queued request SHALL be kept.
REQ-026 Changes on a_in, b_in or cin outside the acceptance edge SHALL have no effect.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH, with cout as the (WIDTH+1)th result bit.

Reset
REQ-028 While rst_n is low, the module SHALL force:
  - state = IDLE;
  - busy = 0, done = 0, cout = 0;
  - sum_out = 0;
  - all internal registers = 0.
REQ-029 Reset asserted mid-operation SHALL abort the addition with no done pulse.
REQ-030 The first start SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-031 Macro SERIAL_ADDER_OVF_EN defined:
  - add port ovf, output, 1 bit;
  - ovf = signed overflow = (carry into MSB) XOR cout;
  - ovf is latched on entry to DONE and held like cout;
  - ovf resets to 0.
REQ-032 Macro SERIAL_ADDER_OVF_EN undefined:
  - port ovf and its logic SHALL be absent;
  - all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-033 a=8'h00, b=8'h00, cin=0, start one cycle -> busy for 8 cycles, then done pulse with sum_out=8'h00, cout=0.
REQ-034 a=8'hFF, b=8'h01, cin=0 -> sum_out=8'h00, cout=1.
REQ-034a a=8'hFF, b=8'hFF, cin=1 -> sum_out=8'hFF, cout=1.
REQ-035 a=8'h7F, b=8'h01, cin=0 with SERIAL_ADDER_OVF_EN -> sum_out=8'h80, cout=0, ovf=1.
REQ-035a a=8'h80, b=8'h80 with SERIAL_ADDER_OVF_EN -> sum_out=8'h00, cout=1, ovf=1.
REQ-036 Start 8'h12+8'h34, then pulse start with 8'hFF+8'hFF during SHIFT -> result still 8'h46, cout=0, exactly one done pulse.
REQ-037 Reset and back-to-back operation:
  - rst_n low on the 4th busy cycle -> all outputs 0 immediately, no done pulse, next start works normally;
  - start held high through DONE -> second op begins with no IDLE cycle;
  - second done exactly WIDTH+1 cycles after the first.
